// File: rtl/sporta_mux.sv
// sporta_mux: packs ADC1/ADC2 snapshots into tagged 16-bit sporta words paced by stream_tick.
// Optional checksum word per frame when SPORTA_MUX_CKSUM_EN is defined.
module sporta_mux #(
    parameter int TICK_DIV = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [111:0] adc1_in,
    input  logic [95:0]  adc2_in,
    input  logic         start,
    input  logic         cont,
    output logic [15:0]  stream,
    output logic         stream_tick,
    output logic         busy,
    output logic         frame_done
);

`ifdef SPORTA_MUX_CKSUM_EN
    localparam logic [4:0] LAST_IDX = 5'd17;
`else
    localparam logic [4:0] LAST_IDX = 5'd16;
`endif
    localparam logic [7:0] DIV_END = 8'(TICK_DIV - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  div_q;
    logic [4:0]  idx_q;
    logic [7:0]  frame_cnt;
    logic [13:0] sh1 [8];
    logic [23:0] sh2 [4];
    logic        accept;
    logic        tick;
    logic        last;
    logic        load;
    logic [15:0] word;
    logic [2:0]  a1;
    logic [2:0]  a2;
    logic [1:0]  ch;

`ifdef SPORTA_MUX_CKSUM_EN
    logic [12:0] cksum_q;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        tick    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start || cont) begin
                    accept  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (div_q == DIV_END) begin
                    tick = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        last = 1'b1;
                        if (!cont)
                            state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // a continuous run re-arms on the last tick with no idle gap
    assign load = accept || (last && cont);

    assign a1 = 3'(idx_q - 5'd1);
    assign a2 = 3'(idx_q - 5'd9);
    assign ch = a2[2:1];

    always_comb begin
        word = '0;
        unique case (1'b1)
            (idx_q == 5'd0):
                word = {8'h00, frame_cnt};
            (idx_q >= 5'd1 && idx_q <= 5'd8):
                word = {2'b01, sh1[a1]};
            (idx_q >= 5'd9 && idx_q <= 5'd16):
                word = a2[0] ? {2'b11, ch, sh2[ch][11:0]}
                             : {2'b10, ch, sh2[ch][23:12]};
`ifdef SPORTA_MUX_CKSUM_EN
            default: word = {3'b001, cksum_q};
`else
            default: word = '0;
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            idx_q       <= '0;
            frame_cnt   <= '0;
            stream      <= '0;
            stream_tick <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stream_tick <= tick;
            frame_done  <= last;
            if (tick)
                stream <= word;
            if (last)
                frame_cnt <= frame_cnt + 8'd1;
            // busy stays up through the last tick, drops the cycle after
            if (accept)
                busy <= 1'b1;
            else if (state_q == IDLE)
                busy <= 1'b0;
            if (load) begin
                div_q <= '0;
                idx_q <= '0;
            end else if (tick) begin
                div_q <= '0;
                idx_q <= idx_q + 5'd1;
            end else if (state_q == SEND) begin
                div_q <= div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 8; k++)
                sh1[k] <= adc1_in[14*k +: 14];
            for (int k = 0; k < 4; k++)
                sh2[k] <= adc2_in[24*k +: 24];
        end
    end

`ifdef SPORTA_MUX_CKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)
            cksum_q <= '0;
        else if (load)
            cksum_q <= '0;
        else if (tick)
            cksum_q <= cksum_q + word[12:0];
    end
`endif

endmodule
